// File: rtl/decoder_executer.sv
// Single-cycle RV32I decode/execute stage: field extraction, immediate generation,
// ALU, branch resolution and next-PC selection, all combinational and gated by reset.
module decoder_executer (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [31:0] i_instruction,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1_val,
   input  logic [31:0] i_rs2_val,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic [31:0] o_imm,
   output logic        o_reg_write,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_illegal,
   output logic [31:0] o_exec_result,
   output logic [31:0] o_jump_dest
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RIDX = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_e;

   // No state is held; the clock is only a timing reference for the surrounding pipeline.
   logic w_unused_clk;
   assign w_unused_clk = &{1'b0, i_clk};

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [RIDX-1:0] w_rs1;
   logic [RIDX-1:0] w_rs2;
   logic [RIDX-1:0] w_rd;

   assign w_opcode = i_instruction[6:0];
   assign w_funct3 = i_instruction[14:12];
   assign w_funct7 = i_instruction[31:25];
   assign w_rs1    = i_instruction[19:15];
   assign w_rs2    = i_instruction[24:20];
   assign w_rd     = i_instruction[11:7];

   fmt_e w_fmt;
   logic w_legal;
   logic w_writes_rd;
   logic w_is_load;
   logic w_is_store;
   logic w_is_branch;
   logic w_is_jal;
   logic w_is_jalr;
   logic w_is_lui;
   logic w_is_auipc;
   logic w_is_alu;
   logic w_alu_reg;

   // Opcode/funct legality and instruction class
   always_comb begin
      w_fmt       = FMT_R;
      w_legal     = 1'b0;
      w_writes_rd = 1'b0;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      w_is_lui    = 1'b0;
      w_is_auipc  = 1'b0;
      w_is_alu    = 1'b0;
      w_alu_reg   = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_fmt       = FMT_U;
            w_legal     = 1'b1;
            w_writes_rd = 1'b1;
            w_is_lui    = 1'b1;
         end
         OPC_AUIPC: begin
            w_fmt       = FMT_U;
            w_legal     = 1'b1;
            w_writes_rd = 1'b1;
            w_is_auipc  = 1'b1;
         end
         OPC_JAL: begin
            w_fmt       = FMT_J;
            w_legal     = 1'b1;
            w_writes_rd = 1'b1;
            w_is_jal    = 1'b1;
         end
         OPC_JALR: begin
            w_fmt       = FMT_I;
            w_legal     = (w_funct3 == 3'b000);
            w_writes_rd = 1'b1;
            w_is_jalr   = 1'b1;
         end
         OPC_BRANCH: begin
            w_fmt       = FMT_B;
            w_legal     = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            w_is_branch = 1'b1;
         end
         OPC_LOAD: begin
            w_fmt       = FMT_I;
            w_legal     = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            w_writes_rd = 1'b1;
            w_is_load   = 1'b1;
         end
         OPC_STORE: begin
            w_fmt       = FMT_S;
            w_legal     = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
            w_is_store  = 1'b1;
         end
         OPC_OPIMM: begin
            w_fmt       = FMT_I;
            w_writes_rd = 1'b1;
            w_is_alu    = 1'b1;
            // Shift-immediates carry funct7 in the upper immediate bits
            case (w_funct3)
               3'b001:  w_legal = (w_funct7 == F7_BASE);
               3'b101:  w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
               default: w_legal = 1'b1;
            endcase
         end
         OPC_OP: begin
            w_fmt       = FMT_R;
            w_writes_rd = 1'b1;
            w_is_alu    = 1'b1;
            w_alu_reg   = 1'b1;
            w_legal     = (w_funct7 == F7_BASE) ||
                          ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   logic [XLEN-1:0] w_imm;

   // Sign-extended immediate by format
   always_comb begin
      w_imm = '0;
      case (w_fmt)
         FMT_I: w_imm = {{20{i_instruction[31]}}, i_instruction[31:20]};
         FMT_S: w_imm = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
         FMT_B: w_imm = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                         i_instruction[30:25], i_instruction[11:8], 1'b0};
         FMT_U: w_imm = {i_instruction[31:12], 12'b0};
         FMT_J: w_imm = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                         i_instruction[20], i_instruction[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end

   logic [XLEN-1:0] w_alu_a;
   logic [XLEN-1:0] w_alu_b;
   logic [4:0]      w_shamt;
   logic            w_alt;
   logic [XLEN-1:0] w_alu_result;

   assign w_alu_a = i_rs1_val;
   assign w_alu_b = w_alu_reg ? i_rs2_val : w_imm;
   assign w_shamt = w_alu_b[4:0];
   assign w_alt   = i_instruction[30];

   // Integer ALU shared by OP and OP-IMM
   always_comb begin
      w_alu_result = '0;
      case (w_funct3)
         3'b000: w_alu_result = (w_alu_reg && w_alt) ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
         3'b001: w_alu_result = w_alu_a << w_shamt;
         3'b010: w_alu_result = {31'b0, ($signed(w_alu_a) < $signed(w_alu_b))};
         3'b011: w_alu_result = {31'b0, (w_alu_a < w_alu_b)};
         3'b100: w_alu_result = w_alu_a ^ w_alu_b;
         3'b101: w_alu_result = w_alt ? XLEN'($signed(w_alu_a) >>> w_shamt) : (w_alu_a >> w_shamt);
         3'b110: w_alu_result = w_alu_a | w_alu_b;
         3'b111: w_alu_result = w_alu_a & w_alu_b;
         default: w_alu_result = '0;
      endcase
   end

   logic w_taken;

   // Branch condition on the two register operands
   always_comb begin
      w_taken = 1'b0;
      case (w_funct3)
         3'b000: w_taken = (i_rs1_val == i_rs2_val);
         3'b001: w_taken = (i_rs1_val != i_rs2_val);
         3'b100: w_taken = ($signed(i_rs1_val) < $signed(i_rs2_val));
         3'b101: w_taken = !($signed(i_rs1_val) < $signed(i_rs2_val));
         3'b110: w_taken = (i_rs1_val < i_rs2_val);
         3'b111: w_taken = !(i_rs1_val < i_rs2_val);
         default: w_taken = 1'b0;
      endcase
   end

   // PC is a word index, so byte offsets are scaled down and link values scaled up
   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_pc_rel;
   logic [XLEN-1:0] w_rs1_plus_imm;
   logic [XLEN-1:0] w_jalr_dest;

   assign w_pc_seq       = i_pc + XLEN'(1);
   assign w_pc_rel       = i_pc + XLEN'($signed(w_imm) >>> 2);
   assign w_rs1_plus_imm = i_rs1_val + w_imm;
   assign w_jalr_dest    = (w_rs1_plus_imm & ~XLEN'(1)) >> 2;

   logic [XLEN-1:0] w_exec;
   logic [XLEN-1:0] w_next;

   // Result and next-PC selection for legal instructions
   always_comb begin
      w_exec = '0;
      w_next = w_pc_seq;
      if (w_is_lui) begin
         w_exec = w_imm;
      end else if (w_is_auipc) begin
         w_exec = (i_pc << 2) + w_imm;
      end else if (w_is_jal) begin
         w_exec = w_pc_seq << 2;
         w_next = w_pc_rel;
      end else if (w_is_jalr) begin
         w_exec = w_pc_seq << 2;
         w_next = w_jalr_dest;
      end else if (w_is_branch) begin
         w_next = w_taken ? w_pc_rel : w_pc_seq;
      end else if (w_is_load) begin
         w_exec = w_rs1_plus_imm;
      end else if (w_is_alu) begin
         w_exec = w_alu_result;
      end
   end

   // Output gating: reset forces zero, illegal forces the trap-like defaults
   always_comb begin
      o_rs1         = '0;
      o_rs2         = '0;
      o_rd          = '0;
      o_imm         = '0;
      o_reg_write   = 1'b0;
      o_mem_read    = 1'b0;
      o_mem_write   = 1'b0;
      o_illegal     = 1'b0;
      o_exec_result = '0;
      o_jump_dest   = '0;
      if (i_rstn) begin
         o_rs1 = w_rs1;
         o_rs2 = w_rs2;
         o_rd  = w_rd;
         if (w_legal) begin
            o_imm         = w_imm;
            o_reg_write   = w_writes_rd && (w_rd != '0);
            o_mem_read    = w_is_load;
            o_mem_write   = w_is_store;
            o_exec_result = w_exec;
            o_jump_dest   = w_next;
         end else begin
            o_illegal   = 1'b1;
            o_jump_dest = w_pc_seq;
         end
      end
   end

endmodule

// File: tb/tb_decoder_executer.sv
// Directed bench for decoder_executer: hand-encoded RV32I words with hand-computed results.
module tb_decoder_executer;

   logic        clk;
   logic        rstn;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        illegal;
   logic [31:0] exec_result;
   logic [31:0] jump_dest;

   int n_vec;
   int n_err;

   decoder_executer dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_instruction (instruction),
      .i_pc          (pc),
      .i_rs1_val     (rs1_val),
      .i_rs2_val     (rs2_val),
      .o_rs1         (rs1),
      .o_rs2         (rs2),
      .o_rd          (rd),
      .o_imm         (imm),
      .o_reg_write   (reg_write),
      .o_mem_read    (mem_read),
      .o_mem_write   (mem_write),
      .o_illegal     (illegal),
      .o_exec_result (exec_result),
      .o_jump_dest   (jump_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs just after a falling edge and let them settle well before the next rising edge
   task automatic apply(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      instruction = ins;
      pc          = p;
      rs1_val     = a;
      rs2_val     = b;
      #2;
   endtask

   task automatic test_reset;
      apply(32'h002181B3, 32'd0, 32'd1, 32'd2);
      n_vec++;
      if ({rs1, rs2, rd, imm, reg_write, mem_read, mem_write, illegal, exec_result, jump_dest} !== '0) begin
         n_err++;
         $display("FAIL reset_zero: got rd=%0d exec=%h jump=%h rw=%b ill=%b, expected all zero",
                  rd, exec_result, jump_dest, reg_write, illegal);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({rs1, rs2, rd, exec_result, jump_dest, reg_write} !== '0) begin
         n_err++;
         $display("FAIL reset_hold_edge: got rd=%0d exec=%h jump=%h, expected all zero", rd, exec_result, jump_dest);
      end
      @(negedge clk);
      #1;
      rstn = 1'b1;
      #1;
      n_vec++;
      if ({rs1, rs2, rd, exec_result, reg_write, jump_dest, illegal} !== {5'd3, 5'd2, 5'd3, 32'd3, 1'b1, 32'd1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_release: got rs1=%0d rs2=%0d rd=%0d exec=%h rw=%b jump=%h ill=%b, expected 3 2 3 00000003 1 00000001 0",
                  rs1, rs2, rd, exec_result, reg_write, jump_dest, illegal);
      end
   endtask

   task automatic test_op;
      apply(32'h002182B3, 32'd11, 32'd23, 32'd2);
      n_vec++;
      if ({rd, exec_result, jump_dest, reg_write} !== {5'd5, 32'd25, 32'd12, 1'b1}) begin
         n_err++;
         $display("FAIL add_x5: got rd=%0d exec=%0d jump=%0d rw=%b, expected 5 25 12 1", rd, exec_result, jump_dest, reg_write);
      end
      apply(32'h402181B3, 32'd0, 32'd1, 32'd2);
      n_vec++;
      if ({exec_result, imm} !== {32'hFFFFFFFF, 32'd0}) begin
         n_err++;
         $display("FAIL sub: got exec=%h imm=%h, expected ffffffff 00000000", exec_result, imm);
      end
      apply(32'h4021D1B3, 32'd0, 32'h80000000, 32'h00000024);
      n_vec++;
      if (exec_result !== 32'hF8000000) begin
         n_err++;
         $display("FAIL sra: got %h, expected f8000000", exec_result);
      end
      apply(32'h0021D1B3, 32'd0, 32'h80000000, 32'h00000024);
      n_vec++;
      if (exec_result !== 32'h08000000) begin
         n_err++;
         $display("FAIL srl: got %h, expected 08000000", exec_result);
      end
      apply(32'h0021A1B3, 32'd0, 32'd1, 32'hFFFFFFFF);
      n_vec++;
      if (exec_result !== 32'd0) begin
         n_err++;
         $display("FAIL slt: got %h, expected 00000000", exec_result);
      end
      apply(32'h0021B1B3, 32'd0, 32'd1, 32'hFFFFFFFF);
      n_vec++;
      if (exec_result !== 32'd1) begin
         n_err++;
         $display("FAIL sltu: got %h, expected 00000001", exec_result);
      end
      apply(32'h0021E1B3, 32'd0, 32'h000000F0, 32'h0000000F);
      n_vec++;
      if (exec_result !== 32'h000000FF) begin
         n_err++;
         $display("FAIL or: got %h, expected 000000ff", exec_result);
      end
   endtask

   task automatic test_imm;
      apply(32'hFFF00093, 32'd0, 32'd0, 32'd0);
      n_vec++;
      if ({imm, exec_result, rd, reg_write} !== {32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1}) begin
         n_err++;
         $display("FAIL addi: got imm=%h exec=%h rd=%0d rw=%b, expected ffffffff ffffffff 1 1", imm, exec_result, rd, reg_write);
      end
      apply(32'h40415093, 32'd0, 32'hF0000000, 32'd0);
      n_vec++;
      if ({imm, exec_result} !== {32'h00000404, 32'hFF000000}) begin
         n_err++;
         $display("FAIL srai: got imm=%h exec=%h, expected 00000404 ff000000", imm, exec_result);
      end
      apply(32'h123450B7, 32'd0, 32'd0, 32'd0);
      n_vec++;
      if ({imm, exec_result, jump_dest} !== {32'h12345000, 32'h12345000, 32'd1}) begin
         n_err++;
         $display("FAIL lui: got imm=%h exec=%h jump=%h, expected 12345000 12345000 00000001", imm, exec_result, jump_dest);
      end
      apply(32'h00001097, 32'd3, 32'd0, 32'd0);
      n_vec++;
      if ({exec_result, jump_dest} !== {32'h0000100C, 32'd4}) begin
         n_err++;
         $display("FAIL auipc: got exec=%h jump=%h, expected 0000100c 00000004", exec_result, jump_dest);
      end
   endtask

   task automatic test_mem;
      apply(32'hFFC12283, 32'd20, 32'h00000100, 32'd0);
      n_vec++;
      if ({exec_result, mem_read, mem_write, reg_write, rd, jump_dest} !== {32'h000000FC, 1'b1, 1'b0, 1'b1, 5'd5, 32'd21}) begin
         n_err++;
         $display("FAIL lw: got exec=%h mr=%b mw=%b rw=%b rd=%0d jump=%0d, expected 000000fc 1 0 1 5 21",
                  exec_result, mem_read, mem_write, reg_write, rd, jump_dest);
      end
      apply(32'h0020A423, 32'd20, 32'h00000100, 32'h55);
      n_vec++;
      if ({imm, mem_read, mem_write, reg_write, jump_dest} !== {32'd8, 1'b0, 1'b1, 1'b0, 32'd21}) begin
         n_err++;
         $display("FAIL sw: got imm=%h mr=%b mw=%b rw=%b jump=%0d, expected 00000008 0 1 0 21",
                  imm, mem_read, mem_write, reg_write, jump_dest);
      end
   endtask

   task automatic test_branch;
      apply(32'h00208463, 32'd4, 32'd7, 32'd7);
      n_vec++;
      if ({jump_dest, reg_write, exec_result, imm} !== {32'd6, 1'b0, 32'd0, 32'd8}) begin
         n_err++;
         $display("FAIL beq_taken: got jump=%0d rw=%b exec=%h imm=%h, expected 6 0 00000000 00000008",
                  jump_dest, reg_write, exec_result, imm);
      end
      apply(32'h00208463, 32'd4, 32'd7, 32'd8);
      n_vec++;
      if ({jump_dest, reg_write} !== {32'd5, 1'b0}) begin
         n_err++;
         $display("FAIL beq_untaken: got jump=%0d rw=%b, expected 5 0", jump_dest, reg_write);
      end
      apply(32'h0020C463, 32'd4, 32'hFFFFFFFF, 32'd1);
      n_vec++;
      if (jump_dest !== 32'd6) begin
         n_err++;
         $display("FAIL blt_taken: got jump=%0d, expected 6", jump_dest);
      end
      apply(32'h0020E463, 32'd4, 32'hFFFFFFFF, 32'd1);
      n_vec++;
      if (jump_dest !== 32'd5) begin
         n_err++;
         $display("FAIL bltu_untaken: got jump=%0d, expected 5", jump_dest);
      end
   endtask

   task automatic test_jump;
      apply(32'hFF9FF0EF, 32'd10, 32'd0, 32'd0);
      n_vec++;
      if ({jump_dest, exec_result, rd, reg_write} !== {32'd8, 32'd44, 5'd1, 1'b1}) begin
         n_err++;
         $display("FAIL jal: got jump=%0d exec=%0d rd=%0d rw=%b, expected 8 44 1 1", jump_dest, exec_result, rd, reg_write);
      end
      apply(32'h00C100E7, 32'd5, 32'h00000101, 32'd0);
      n_vec++;
      if ({jump_dest, exec_result, reg_write} !== {32'h00000043, 32'd24, 1'b1}) begin
         n_err++;
         $display("FAIL jalr: got jump=%h exec=%0d rw=%b, expected 00000043 24 1", jump_dest, exec_result, reg_write);
      end
   endtask

   task automatic test_illegal;
      apply(32'h00000000, 32'd9, 32'd5, 32'd6);
      n_vec++;
      if ({illegal, reg_write, mem_read, mem_write, exec_result, jump_dest} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd10}) begin
         n_err++;
         $display("FAIL illegal_zero: got ill=%b rw=%b mr=%b mw=%b exec=%h jump=%0d, expected 1 0 0 0 00000000 10",
                  illegal, reg_write, mem_read, mem_write, exec_result, jump_dest);
      end
      apply(32'h022181B3, 32'd7, 32'd5, 32'd6);
      n_vec++;
      if ({illegal, reg_write, exec_result, jump_dest} !== {1'b1, 1'b0, 32'd0, 32'd8}) begin
         n_err++;
         $display("FAIL illegal_mul: got ill=%b rw=%b exec=%h jump=%0d, expected 1 0 00000000 8",
                  illegal, reg_write, exec_result, jump_dest);
      end
      apply(32'h00218033, 32'd0, 32'd1, 32'd2);
      n_vec++;
      if ({illegal, rd, reg_write, exec_result} !== {1'b0, 5'd0, 1'b0, 32'd3}) begin
         n_err++;
         $display("FAIL rd_zero: got ill=%b rd=%0d rw=%b exec=%h, expected 0 0 0 00000003", illegal, rd, reg_write, exec_result);
      end
   endtask

   task automatic test_back_to_back;
      apply(32'h002181B3, 32'd0, 32'd1, 32'd2);
      #1;
      rstn = 1'b0;
      #1;
      n_vec++;
      if ({exec_result, jump_dest, rd, reg_write} !== '0) begin
         n_err++;
         $display("FAIL async_assert: got exec=%h jump=%h rd=%0d rw=%b, expected all zero", exec_result, jump_dest, rd, reg_write);
      end
      #1;
      rstn = 1'b1;
      #1;
      n_vec++;
      if ({rs1, rs2, rd, exec_result, jump_dest, reg_write} !== {5'd3, 5'd2, 5'd3, 32'd3, 32'd1, 1'b1}) begin
         n_err++;
         $display("FAIL async_release: got rd=%0d exec=%h jump=%h rw=%b, expected 3 00000003 00000001 1",
                  rd, exec_result, jump_dest, reg_write);
      end
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rstn        = 1'b0;
      instruction = 32'd0;
      pc          = 32'd0;
      rs1_val     = 32'd0;
      rs2_val     = 32'd0;
      test_reset;
      test_op;
      test_imm;
      test_mem;
      test_branch;
      test_jump;
      test_illegal;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
